// File: rtl/fpu_pkg.sv
// Shared FPU opcode encodings and arbiter state type.
// Imported by the FPU arbiter slice.
package fpu_pkg;

  localparam logic [3:0] FADD   = 4'd0;
  localparam logic [3:0] FSUB   = 4'd1;
  localparam logic [3:0] FMUL   = 4'd2;
  localparam logic [3:0] FDIV   = 4'd3;
  localparam logic [3:0] FSQRT  = 4'd4;
  localparam logic [3:0] FSGNJ  = 4'd5;
  localparam logic [3:0] FSGNJN = 4'd6;
  localparam logic [3:0] FSGNJX = 4'd7;
  localparam logic [3:0] FEQ    = 4'd8;
  localparam logic [3:0] FLE    = 4'd9;
  localparam logic [3:0] FLT    = 4'd10;
  localparam logic [3:0] FCVTWS = 4'd11;
  localparam logic [3:0] FCVTSW = 4'd12;
  localparam logic [3:0] FNOP   = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester-side bundle of the FPU arbiter:
// two request ports in, one shared response bus out.
interface fpu_arbiter_if #(
  parameter int TAG_W = 5
);

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_src0;
  logic [1:0][31:0]      req_src1;
  logic [1:0][3:0]       req_op;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [31:0]           rsp_data;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_err;

  modport master (
    output req_valid, req_src0, req_src1,
    output req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_src0, req_src1,
    input  req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_tag, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port
// that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the valid pattern and last winner
  always_comb begin
    grant_o = 2'b00;
    unique case (1'b1)
      (valid_i == 2'b11): grant_o = last_i ? 2'b01 : 2'b10;
      (valid_i == 2'b01): grant_o = 2'b01;
      (valid_i == 2'b10): grant_o = 2'b10;
      default:            grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one multi-cycle FPU between two requesters.
// Optional EXEC watchdog: define FPU_ARB_WATCHDOG_EN.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  fpu_arbiter_if.slave bus,
  output logic [31:0] fpu_src0_o,
  output logic [31:0] fpu_src1_o,
  output logic [3:0]  fpu_op_o,
  input  logic [31:0] fpu_result_i,
  input  logic        fpu_fin_i
);

  arb_state_e       state_q;
  logic             rr_last_q;
  logic             owner_q;
  logic [31:0]      src0_q;
  logic [31:0]      src1_q;
  logic [3:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic [1:0]       rsp_valid_q;
  logic             err_q;

  logic [1:0] gnt;
  logic       g;
  logic       accept;

  rr_arb2 u_rr_arb2 (
    .valid_i (bus.req_valid),
    .last_i  (rr_last_q),
    .grant_o (gnt)
  );

  assign g = gnt[1];

  assign bus.req_ready =
    (rstn && state_q == IDLE) ? gnt : 2'b00;

  assign accept = |(bus.req_ready & bus.req_valid);

  assign fpu_src0_o    = src0_q;
  assign fpu_src1_o    = src1_q;
  assign fpu_op_o      = op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_tag   = tag_q;
  assign bus.rsp_err   = err_q;

`ifdef FPU_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q;
`endif

  // Arbiter FSM; op_q reads FNOP outside EXEC
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      src0_q      <= '0;
      src1_q      <= '0;
      op_q        <= FNOP;
      tag_q       <= '0;
      data_q      <= '0;
      rsp_valid_q <= 2'b00;
      err_q       <= 1'b0;
`ifdef FPU_ARB_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            src0_q    <= bus.req_src0[g];
            src1_q    <= bus.req_src1[g];
            op_q      <= bus.req_op[g];
            tag_q     <= bus.req_tag[g];
            owner_q   <= g;
            rr_last_q <= g;
            state_q   <= EXEC;
`ifdef FPU_ARB_WATCHDOG_EN
            wd_q      <= '0;
`endif
          end
        end
        EXEC: begin
          if (fpu_fin_i) begin
            data_q      <= fpu_result_i;
            op_q        <= FNOP;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
`ifdef FPU_ARB_WATCHDOG_EN
          end else if (wd_q == WD_LAST) begin
            data_q      <= '0;
            err_q       <= 1'b1;
            op_q        <= FNOP;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            err_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares the single multi-cycle FPU datapath between two requesters: port 0 is the integer/FP pipeline, port 1 is the auxiliary unit.
- Latches the winning request's operands and opcode, then holds them stable on the FPU inputs until the FPU asserts fin.
- Captures the result into a response register and routes it back to the originating port with its tag.
- Sits between the issue logic and the fpu instance; it is the only driver of the fpu src0/src1/fpuop pins.

Parameters:
- TAG_W, 5, width of the requester tag (destination register id), echoed in the response.
- TIMEOUT, 16, watchdog limit in EXEC cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accepted this cycle
- req_src0  in  2x32  per-port operand 0
- req_src1  in  2x32  per-port operand 1
- req_op  in  2x4  per-port fpuop encoding
- req_tag  in  2xTAG_W  per-port tag
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response accept
- rsp_data  out  32  response result (shared bus)
- rsp_tag  out  TAG_W  response tag (shared bus)
- rsp_err  out  1  watchdog error flag; constant 0 without the optional feature
- fpu_src0  out  32  to fpu src0
- fpu_src1  out  32  to fpu src1
- fpu_op  out  4  to fpu fpuop
- fpu_result  in  32  from fpu result
- fpu_fin  in  1  from fpu fin

Behaviour:
- Reset is synchronous on rstn=0:
  - state=IDLE, rr_last=1 (so port 0 wins the first tie).
  - All operand/op/tag/result registers cleared.
  - req_ready=0, rsp_valid=0, rsp_err=0.
  - fpu_op=4'b1111, fpu_src0/1=0.
- NOP: fpu_op=4'b1111 whenever state is not EXEC. With this code the fpu state counter does not advance and its result reads 0.
- IDLE:
  - Grant is combinational: if only one req_valid is high, that port wins; if both are high, the port != rr_last wins.
  - req_ready[g]=1 only for the granted port, and only while in IDLE.
  - On handshake: latch src0/src1/op/tag and the owner bit g, set rr_last=g, go to EXEC.
- EXEC:
  - Drive the latched operands and op; hold them constant every cycle.
  - On a cycle with fpu_fin=1: capture fpu_result into rsp_data, go to RESP.
  - fpu_fin is authoritative. Required latencies, counted from the accept cycle t to the first rsp_valid cycle:
    - fadd/fsub/fmul (op 0-2): t+5.
    - fdiv (op 3): t+12.
    - fsqrt (op 4): t+10.
    - ops 5-12: t+2.
    - ops 13-15: t+2 with result 0.
- RESP:
  - rsp_valid[owner]=1 and the other bit 0; rsp_tag=latched tag.
  - When rsp_ready[owner]=1, go to IDLE. Data and tag hold until then.
  - fpu_op=NOP, so the fpu counter returns to 0 before the next op.
- Throughput: at most one op in flight. Back-to-back minimum is RESP→IDLE→accept, i.e. one bubble cycle of IDLE.
- A req_valid that drops before acceptance is simply not granted; no state change results.
- Simultaneous events:
  - A request arriving while in EXEC or RESP waits with req_ready=0.
  - A new request on the owner port during RESP is not accepted until IDLE.
- Reset mid-operation: return to IDLE immediately and drop the in-flight op (no response). The fpu shares rstn and also resets.
- rsp_ready on the non-owner port is ignored.

Optional Feature:
- Macro: FPU_ARB_WATCHDOG_EN.
- Defined:
  - An EXEC cycle counter, cleared on entry to EXEC.
  - If the count reaches TIMEOUT without fpu_fin, go to RESP with rsp_data=0 and rsp_err=1.
  - rsp_err clears when the response is accepted.
- Undefined: no counter is built, rsp_err is tied to 0, and EXEC waits indefinitely.

Decomposition:
- Package fpu_pkg holds:
  - the fpuop encoding constants: FADD=0, FSUB=1, FMUL=2, FDIV=3, FSQRT=4, FSGNJ=5, FSGNJN=6, FSGNJX=7, FEQ=8, FLE=9, FLT=10, FCVTWS=11, FCVTSW=12, FNOP=15;
  - the arbiter state enum {IDLE, EXEC, RESP}.
- Sub-module rr_arb2 contains the two-way round-robin grant logic (inputs valid[1:0] and last; output one-hot grant).

Test Plan:
- Port 0 fadd: src0=0x3F800000, src1=0x40000000 accepted at t -> rsp_valid[0] at t+5, rsp_data=0x40400000, tag echoed.
- Both ports valid at the same cycle after reset, each fmul 0x40000000*0x40400000 -> port 0 served first, then port 1; both return 0x40C00000; port 1 req_ready rises only after port 0's response is accepted.
- fdiv 0x40C00000/0x40000000 -> rsp_data=0x40400000 at t+12; fpu_src0/src1/op held constant throughout EXEC.
- Hold rsp_ready[1]=0 for 5 cycles in RESP -> rsp_valid[1], data and tag stable; no new grant; fpu_op=4'b1111.
- Assert rstn=0 during the 3rd EXEC cycle of fsqrt -> next cycle IDLE, no rsp_valid, fpu_op=4'b1111.
- With FPU_ARB_WATCHDOG_EN and fpu_fin forced to 0 -> response after TIMEOUT=16 EXEC cycles, rsp_err=1, rsp_data=0.
